// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned multiplier: one shift-add step per cycle through a
// single 8-bit ripple adder, with a one-cycle done pulse and a held product.

module adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum,
  output logic       c_out
);

  logic [8:0] carry_s;

  // Ripple-carry chain, bit 0 upward
  always_comb begin
    carry_s    = 9'h000;
    sum        = 8'h00;
    carry_s[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry_s[i];
      carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end
    c_out = carry_s[8];
  end

endmodule

module mul8_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [7:0]  mcand_r, mcand_nxt_s;
  logic [7:0]  acc_hi_r, acc_hi_nxt_s;
  logic [7:0]  acc_lo_r, acc_lo_nxt_s;
  logic [3:0]  cnt_r, cnt_nxt_s;
  logic [15:0] product_r, product_nxt_s;
  logic [7:0]  addend_s;
  logic [7:0]  sum_s;
  logic        c_out_s;

  assign addend_s = acc_lo_r[0] ? mcand_r : 8'h00;

  adder8 u_adder8 (
    .a     (acc_hi_r),
    .b     (addend_s),
    .sum   (sum_s),
    .c_out (c_out_s)
  );

  // Next-state and datapath update; a start in IDLE or DONE loads fresh operands
  always_comb begin
    state_nxt_s   = state_r;
    mcand_nxt_s   = mcand_r;
    acc_hi_nxt_s  = acc_hi_r;
    acc_lo_nxt_s  = acc_lo_r;
    cnt_nxt_s     = cnt_r;
    product_nxt_s = product_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          mcand_nxt_s  = a;
          acc_hi_nxt_s = 8'h00;
          acc_lo_nxt_s = b;
          cnt_nxt_s    = 4'd0;
          state_nxt_s  = RUN;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      RUN: begin
        // The carry lands in acc_hi[7]; sum[0] shifts into the low half
        acc_hi_nxt_s = {c_out_s, sum_s[7:1]};
        acc_lo_nxt_s = {sum_s[0], acc_lo_r[7:1]};
        cnt_nxt_s    = cnt_r + 4'd1;
        if (cnt_r == 4'd7) begin
          state_nxt_s   = DONE;
          product_nxt_s = {c_out_s, sum_s[7:1], sum_s[0], acc_lo_r[7:1]};
        end else begin
          state_nxt_s   = RUN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      mcand_r   <= 8'h00;
      acc_hi_r  <= 8'h00;
      acc_lo_r  <= 8'h00;
      cnt_r     <= 4'd0;
      product_r <= 16'h0000;
    end else begin
      state_r   <= state_nxt_s;
      mcand_r   <= mcand_nxt_s;
      acc_hi_r  <= acc_hi_nxt_s;
      acc_lo_r  <= acc_lo_nxt_s;
      cnt_r     <= cnt_nxt_s;
      product_r <= product_nxt_s;
    end
  end

  assign busy    = (state_r == RUN);
  assign done    = (state_r == DONE);
  assign product = product_r;

endmodule

// File: doc/mul8_seq.md
MUL8_SEQ -- requirements
Module: mul8_seq

Interface
REQ-001 Parameters: none; operand width is fixed at 8 bits and product width at 16 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  request to begin a multiply; sampled only when busy=0.
REQ-005 a  input  8  multiplicand, unsigned; captured on accepted start.
REQ-006 b  input  8  multiplier, unsigned; captured on accepted start.
REQ-007 busy  output  1  high while a multiply is in progress (RUN state).
REQ-008 done  output  1  single-cycle pulse marking a new valid product.
REQ-009 product  output  16  unsigned a*b of the most recently completed multiply.

Function
REQ-010 Algorithm: unsigned shift-add, one 8-bit addition per RUN cycle, LSB-first on the multiplier.
REQ-011 The per-step addition SHALL use one instance of the team's adder8 block (8-bit ripple sum plus c_out); no other adder or multiplier operator is permitted on the datapath.
REQ-012 Internal state: mcand[7:0], acc_hi[7:0], acc_lo[7:0], cnt[3:0], 2-bit FSM {IDLE, RUN, DONE}.
REQ-013 Accept: start=1 with FSM in IDLE or DONE at edge k -> mcand<=a, acc_hi<=0, acc_lo<=b, cnt<=0, FSM<=RUN.
REQ-014 RUN step: adder operands are acc_hi and (acc_lo[0] ? mcand : 8'h00); {acc_hi, acc_lo} <= {c_out, sum[7:0], acc_lo[7:1]}; cnt<=cnt+1.
REQ-015 RUN exits after exactly 8 steps (cnt reaching 7 on the current step) -> FSM<=DONE, product<={next acc_hi, next acc_lo}.
REQ-016 Latency: start accepted at edge k -> busy=1 during cycles k+1..k+8, done=1 and product valid in cycle k+9.
REQ-017 busy SHALL be 1 exactly when FSM=RUN; done SHALL be 1 exactly when FSM=DONE.
REQ-018 DONE lasts one cycle: next edge -> IDLE if start=0, else accept per REQ-013 (back-to-back operation, no idle gap).
REQ-019 start while FSM=RUN SHALL be ignored; a, b changes during RUN SHALL NOT affect the result.
REQ-020 product register is written only on RUN->DONE; it holds its value through IDLE, subsequent RUN and accepted starts until the next completion.
REQ-021 Arithmetic: result exact for all 65,536 operand pairs; maximum 0xFF*0xFF = 0xFE01 produces no overflow; c_out of each step is retained as acc_hi[7] of the next state.
REQ-022 Outputs driven directly from registers (busy, done decoded from FSM register only); no combinational path from inputs to outputs.

Reset
REQ-023 reset=1 at an edge: FSM<=IDLE, busy=0, done=0, product=16'h0000, cnt=0, mcand/acc=0.
REQ-024 reset has priority over start and over any in-progress RUN step; an aborted multiply produces no done pulse and leaves product=0.
REQ-025 start sampled in the same cycle as reset=1 SHALL be ignored; first acceptable start is at the edge after reset deasserts.

Verification
REQ-026 After reset, start with a=0x0D, b=0x0B -> busy high 8 cycles, done pulse in cycle k+9, product=0x008F.
REQ-027 a=0xFF, b=0xFF -> product=0xFE01; a=0x00, b=0xFF -> product=0x0000; a=0x80, b=0x02 -> product=0x0100.
REQ-028 start with a=0x03, b=0x05, then start=1 with a=0xFF, b=0xFF held through RUN -> single done, product=0x000F, no second operation begins until DONE.
REQ-029 start held high continuously with a=0x10, b=0x10 -> done pulses every 9 cycles, product=0x0100 each time, busy low only in DONE cycles.
REQ-030 Reset asserted at the 4th RUN cycle of 0x12*0x34 -> busy=0, done never pulses, product=0x0000; next start 0x12*0x34 -> product=0x03A8.
REQ-031 Randomized run of at least 10,000 operand pairs against a reference model, including back-to-back starts -> all products exact, done count equals accepted-start count.
